prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 161 ++++++++++++++++
 tb/tb_prog_loader.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Boot-time program loader: receives a length/payload/checksum byte frame and writes
// the payload into instruction memory while holding the processor in reset.
module prog_loader #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       imem_we,
    output logic [7:0] imem_addr,
    output logic [7:0] imem_wdata,
    output logic       cpu_hold,
    output logic       done,
    output logic       err
);

    localparam int unsigned StallW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [StallW-1:0] StallLast = (TIMEOUT == 0) ? '0 : StallW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StData,
        StCsum,
        StDone,
        StErr
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        addr_q, addr_d;
    logic [7:0]        sum_q, sum_d;
    logic [StallW-1:0] stall_q, stall_d;
    logic              we_q, we_d;
    logic [7:0]        waddr_q, waddr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic       active;
    logic       accept;
    logic [7:0] last_addr;

    assign active    = (state_q == StLen) || (state_q == StData) || (state_q == StCsum);
    assign accept    = active && in_valid;
    // Length 0 wraps to 255 here, which is exactly the last address of a 256-byte frame.
    assign last_addr = len_q - 8'd1;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        addr_d  = addr_q;
        sum_d   = sum_q;
        stall_d = stall_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        hold_d  = hold_q;
        done_d  = done_q;
        err_d   = err_q;

        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    state_d = StLen;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    hold_d  = 1'b1;
                    stall_d = '0;
                end
            end
            StLen: begin
                if (accept) begin
                    len_d   = in_data;
                    addr_d  = 8'd0;
                    sum_d   = 8'd0;
                    state_d = StData;
                end
            end
            StData: begin
                if (accept) begin
                    we_d    = 1'b1;
                    waddr_d = addr_q;
                    wdata_d = in_data;
                    addr_d  = addr_q + 8'd1;
                    sum_d   = sum_q + in_data;
                    if (addr_q == last_addr) begin
                        state_d = StCsum;
                    end
                end
            end
            StCsum: begin
                if (accept) begin
                    if (in_data == sum_q) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = StErr;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Idle-cycle watchdog; the TIMEOUT-th consecutive idle cycle aborts the frame.
        if (active) begin
            if (accept) begin
                stall_d = '0;
            end else if (stall_q >= StallLast) begin
                state_d = StErr;
                err_d   = 1'b1;
                stall_d = '0;
            end else begin
                stall_d = stall_q + StallW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            len_q   <= 8'd0;
            addr_q  <= 8'd0;
            sum_q   <= 8'd0;
            stall_q <= '0;
            we_q    <= 1'b0;
            waddr_q <= 8'd0;
            wdata_q <= 8'd0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            sum_q   <= sum_d;
            stall_q <= stall_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign in_ready   = active;
    assign imem_we    = we_q;
    assign imem_addr  = waddr_q;
    assign imem_wdata = wdata_q;
    assign cpu_hold   = hold_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: a frame-level model predicts memory writes and the
// final status; a negedge monitor pops and compares everything the DUT presents.
module tb_prog_loader;

    logic       clk;
    logic       reset;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       imem_we;
    logic [7:0] imem_addr;
    logic [7:0] imem_wdata;
    logic       cpu_hold;
    logic       done;
    logic       err;

    prog_loader #(.TIMEOUT(255)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef logic [7:0] byte_q_t[$];
    typedef struct { logic [7:0] addr; logic [7:0] data; int cyc; } wr_t;
    typedef struct { logic done; logic err; logic hold; } st_t;
    typedef struct { string name; int kind; logic [20:0] mask; logic [20:0] exp; } snap_t;

    // Snapshot layout: {err, done, hold, wdata[7:0], addr[7:0], we, ready}
    localparam logic [20:0] M_RDY  = 21'h000001;
    localparam logic [20:0] M_HOLD = 21'h040000;
    localparam logic [20:0] M_DONE = 21'h080000;
    localparam logic [20:0] M_ERR  = 21'h100000;
    localparam logic [20:0] M_ALL  = 21'h1FFFFF;

    wr_t   exp_wr[$];
    st_t   exp_st[$];
    snap_t snaps[$];
    int    n_vec = 0;
    int    n_bad = 0;

    function automatic logic [20:0] ev(logic rdy, logic hold, logic dn, logic er);
        return {er, dn, hold, 8'h00, 8'h00, 1'b0, rdy};
    endfunction

    task automatic push_snap(input string name, input logic [20:0] mask,
                             input logic [20:0] exp);
        snaps.push_back('{name: name, kind: 0, mask: mask, exp: exp});
    endtask

    // Monitor: the only process that compares and counts.
    initial begin : monitor
        logic [20:0] act;
        logic        prev_de;
        wr_t         w;
        st_t         s;
        snap_t       p;
        prev_de = 1'b0;
        forever begin
            @(negedge clk);
            act = {err, done, cpu_hold, imem_wdata, imem_addr, imem_we, in_ready};
            if (imem_we === 1'b1) begin
                n_vec++;
                if (exp_wr.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_write: got %02h@%02h cyc %0d, required no write",
                             imem_wdata, imem_addr, cyc);
                end else begin
                    w = exp_wr.pop_front();
                    if (imem_addr !== w.addr || imem_wdata !== w.data || cyc != w.cyc) begin
                        n_bad++;
                        $display("FAIL write: got %02h@%02h cyc %0d, required %02h@%02h cyc %0d",
                                 imem_wdata, imem_addr, cyc, w.data, w.addr, w.cyc);
                    end
                end
            end
            if ((done === 1'b1 || err === 1'b1) && !prev_de) begin
                n_vec++;
                if (exp_st.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_status: got done=%b err=%b, required none",
                             done, err);
                end else begin
                    s = exp_st.pop_front();
                    if (done !== s.done || err !== s.err || cpu_hold !== s.hold) begin
                        n_bad++;
                        $display("FAIL status: got done=%b err=%b hold=%b, required %b %b %b",
                                 done, err, cpu_hold, s.done, s.err, s.hold);
                    end
                end
            end
            if (done === 1'b1 || err === 1'b1) begin
                n_vec++;
                if (done && err) begin
                    n_bad++;
                    $display("FAIL done_err_exclusive: got done=1 err=1, required not both");
                end
            end
            prev_de = (done === 1'b1) || (err === 1'b1);
            while (snaps.size() > 0) begin
                p = snaps.pop_front();
                n_vec++;
                if (p.kind == 1) begin
                    if (exp_wr.size() != 0 || exp_st.size() != 0) begin
                        n_bad++;
                        $display("FAIL %s: got %0d writes/%0d status pending, required 0/0",
                                 p.name, exp_wr.size(), exp_st.size());
                    end
                end else if ((act & p.mask) !== (p.exp & p.mask)) begin
                    n_bad++;
                    $display("FAIL %s: got %06h, required %06h (mask %06h)",
                             p.name, act & p.mask, p.exp & p.mask, p.mask);
                end
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        push_snap("reset_outputs", M_ALL, 21'h0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        push_snap("after_start", M_RDY | M_HOLD | M_DONE | M_ERR, ev(1'b1, 1'b1, 1'b0, 1'b0));
    endtask

    task automatic send_byte(input logic [7:0] b, output int acc);
        in_valid = 1'b1;
        in_data  = b;
        push_snap("in_ready", M_RDY, ev(1'b1, 1'b0, 1'b0, 1'b0));
        @(posedge clk); #1;
        acc      = cyc;
        in_valid = 1'b0;
    endtask

    task automatic idle_gap(input int n, input bit rnd_start);
        for (int k = 0; k < n; k++) begin
            start = rnd_start && ($urandom_range(3, 0) == 0);
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 40 && (exp_wr.size() != 0 || exp_st.size() != 0); k++) begin
            @(posedge clk);
        end
        #1;
        snaps.push_back('{name: name, kind: 1, mask: '0, exp: '0});
        @(posedge clk); #1;
    endtask

    // Frame-level reference: payload[i] lands at address i; status from mod-256 sum.
    task automatic run_frame(input logic [7:0] len_b, input byte_q_t pay, input logic [7:0] csum,
                             input int gmin, input int gmax, input bit rnd_start);
        int acc;
        int sum;
        bit ok;
        sum = 0;
        foreach (pay[i]) sum += int'(pay[i]);
        ok = ((sum % 256) == int'(csum));
        pulse_start();
        send_byte(len_b, acc);
        idle_gap(int'($urandom_range(gmax, gmin)), rnd_start);
        foreach (pay[i]) begin
            send_byte(pay[i], acc);
            exp_wr.push_back('{addr: 8'(i), data: pay[i], cyc: acc});
            idle_gap(int'($urandom_range(gmax, gmin)), rnd_start);
        end
        exp_st.push_back('{done: ok, err: !ok, hold: !ok});
        send_byte(csum, acc);
        drain("frame_drain");
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        byte_q_t     pay;
        int          acc;
        int          len;
        int          sum;
        logic [7:0]  cs;
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        @(posedge clk); #1;
        do_reset();

        pay = '{8'h11, 8'h22, 8'h33};
        run_frame(8'h03, pay, 8'h66, 0, 0, 1'b0);

        pay = '{8'h01, 8'h02};
        run_frame(8'h02, pay, 8'h04, 0, 0, 1'b0);

        pay = '{8'h11, 8'h22, 8'h33};
        run_frame(8'h03, pay, 8'h66, 10, 10, 1'b0);

        // Timeout: one payload byte, then 255 idle cycles.
        pulse_start();
        send_byte(8'h04, acc);
        send_byte(8'hAA, acc);
        exp_wr.push_back('{addr: 8'h00, data: 8'hAA, cyc: acc});
        repeat (254) @(posedge clk);
        #1;
        push_snap("timeout_early", M_ERR | M_HOLD | M_RDY, ev(1'b1, 1'b1, 1'b0, 1'b0));
        exp_st.push_back('{done: 1'b0, err: 1'b1, hold: 1'b1});
        @(posedge clk); #1;
        push_snap("timeout_err", M_ALL & ~21'h3FFFE, ev(1'b0, 1'b1, 1'b0, 1'b1));
        idle_gap(20, 1'b0);
        drain("timeout_drain");

        // Length 0 means 256 bytes.
        pay.delete();
        for (int i = 0; i < 256; i++) pay.push_back(8'(i));
        run_frame(8'h00, pay, 8'h80, 0, 0, 1'b0);

        // Reset mid-DATA after two of five payload bytes.
        pulse_start();
        send_byte(8'h05, acc);
        send_byte(8'hA1, acc);
        exp_wr.push_back('{addr: 8'h00, data: 8'hA1, cyc: acc});
        send_byte(8'hB2, acc);
        exp_wr.push_back('{addr: 8'h01, data: 8'hB2, cyc: acc});
        do_reset();
        idle_gap(5, 1'b0);
        drain("reset_drain");
        pay = '{8'h11, 8'h22, 8'h33};
        run_frame(8'h03, pay, 8'h66, 0, 0, 1'b0);

        // Reset wins over a simultaneous start.
        start = 1'b1;
        do_reset();
        start = 1'b0;
        idle_gap(2, 1'b0);

        // Randomized frames with gaps, stray start pulses and corrupted checksums.
        for (int f = 0; f < 20; f++) begin
            len = int'($urandom_range(24, 1));
            pay.delete();
            sum = 0;
            for (int i = 0; i < len; i++) begin
                pay.push_back(8'($urandom_range(255, 0)));
                sum += int'(pay[i]);
            end
            cs = 8'(sum % 256);
            if ($urandom_range(3, 0) == 0) cs = cs ^ 8'($urandom_range(255, 1));
            run_frame(8'(len), pay, cs, 0, 4, 1'b1);
        end

        drain("final_drain");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
